// File: rtl/fifo_burst_writer_if.sv
// Stream-in / FIFO-write-out bundle for fifo_burst_writer.
// master = burst writer; slave = upstream source plus FIFO.
interface fifo_burst_writer_if #(
  parameter int P_DATA_WIDE = 8
);

  logic                   s_valid;
  logic [P_DATA_WIDE-1:0] s_data;
  logic                   s_ready;
  logic                   fifo_wr_en;
  logic [P_DATA_WIDE-1:0] fifo_wr_din;
  logic                   fifo_full;
  logic                   fifo_almost_full;

  modport master (
    input  s_valid,
    input  s_data,
    input  fifo_full,
    input  fifo_almost_full,
    output s_ready,
    output fifo_wr_en,
    output fifo_wr_din
  );

  modport slave (
    output s_valid,
    output s_data,
    output fifo_full,
    output fifo_almost_full,
    input  s_ready,
    input  fifo_wr_en,
    input  fifo_wr_din
  );

endinterface

// File: rtl/fifo_burst_writer.sv
// Burst write master: moves burst_len stream beats into the FIFO.
// Optional stall counter enabled by defining WR_STALL_CNT_EN.
module fifo_burst_writer #(
  parameter int P_DATA_WIDE = 8,
  parameter int P_LEN_WIDE  = 16
) (
  input  logic                  rst,
  input  logic                  wr_clk,
  input  logic                  start,
  input  logic [P_LEN_WIDE-1:0] burst_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [P_LEN_WIDE-1:0] wr_count,
  output logic [15:0]           stall_cnt,
  fifo_burst_writer_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [P_LEN_WIDE-1:0]  remaining;
  logic [P_LEN_WIDE-1:0]  rem_nxt;
  logic [P_LEN_WIDE-1:0]  cnt_nxt;
  logic                   ready_w;
  logic                   accept;
  logic                   start_ok;
  logic                   wr_en_q;
  logic [P_DATA_WIDE-1:0] din_q;

  assign ready_w  = (state == RUN)
                  && !bus.fifo_almost_full
                  && !bus.fifo_full;
  assign accept   = bus.s_valid && ready_w;
  assign start_ok = (state == IDLE) && start;

  assign bus.s_ready     = ready_w;
  assign bus.fifo_wr_en  = wr_en_q;
  assign bus.fifo_wr_din = din_q;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Next state and burst counters; abort beats the last-beat exit.
  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    cnt_nxt   = wr_count;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt = '0;
          if (burst_len != '0) begin
            state_nxt = RUN;
            rem_nxt   = burst_len;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (accept) begin
          rem_nxt = remaining - P_LEN_WIDE'(1);
          cnt_nxt = wr_count + P_LEN_WIDE'(1);
        end
        if (abort) begin
          state_nxt = IDLE;
        end else if (accept
                     && remaining == P_LEN_WIDE'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and the one-cycle write pipeline.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      wr_count  <= '0;
      wr_en_q   <= 1'b0;
      din_q     <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      wr_count  <= cnt_nxt;
      wr_en_q   <= accept;
      if (accept) begin
        din_q <= bus.s_data;
      end
    end
  end

`ifdef WR_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stall_hit;

  assign stall_hit = (state == RUN)
                   && bus.s_valid
                   && !ready_w;
  assign stall_cnt = stall_q;

  // Saturating count of cycles the source waited on the FIFO.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (stall_hit
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`else
  logic unused_start_ok;

  assign unused_start_ok = start_ok;
  assign stall_cnt       = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer.
// Each scenario task drives stimulus and checks inline.
module tb_fifo_burst_writer;

  localparam int DW = 8;
  localparam int LW = 16;

  logic          wr_clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [LW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic [LW-1:0] wr_count;
  logic [15:0]   stall_cnt;

  fifo_burst_writer_if #(.P_DATA_WIDE(DW)) bus ();

  fifo_burst_writer #(
    .P_DATA_WIDE(DW),
    .P_LEN_WIDE (LW)
  ) dut (
    .rst      (rst),
    .wr_clk   (wr_clk),
    .start    (start),
    .burst_len(burst_len),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count),
    .stall_cnt(stall_cnt),
    .bus      (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] wq[$];
  int   n_done    = 0;
  int   n_busy    = 0;
  int   n_clash   = 0;
  int   n_done_wr = 0;
  logic acc       = 1'b0;

  always @(negedge wr_clk) begin
    if (bus.fifo_wr_en === 1'b1) wq.push_back(bus.fifo_wr_din);
    if (done === 1'b1) n_done++;
    if (busy === 1'b1) n_busy++;
    if (bus.fifo_wr_en === 1'b1 && bus.fifo_full === 1'b1)
      n_clash++;
    if (done === 1'b1 && bus.fifo_wr_en === 1'b1)
      n_done_wr++;
    acc = (bus.s_valid === 1'b1) && (bus.s_ready === 1'b1);
  end

  task automatic step();
    @(posedge wr_clk);
    #1;
    if (acc) bus.s_data = bus.s_data + 8'd1;
  endtask

  task automatic clear_mon();
    wq.delete();
    n_done    = 0;
    n_busy    = 0;
    n_clash   = 0;
    n_done_wr = 0;
  endtask

  task automatic test_reset();
    rst                  = 1'b1;
    start                = 1'b0;
    abort                = 1'b0;
    burst_len            = '0;
    bus.s_valid          = 1'b0;
    bus.s_data           = '0;
    bus.fifo_full        = 1'b0;
    bus.fifo_almost_full = 1'b0;
    #3;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0",
               busy, done);
    end
    total++;
    if (wr_count !== 16'd0 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnt wr_count=%0d stall=%0d want 0 0",
               wr_count, stall_cnt);
    end
    total++;
    if (bus.fifo_wr_en !== 1'b0 || bus.fifo_wr_din !== 8'd0
        || bus.s_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus wr_en=%b din=%h rdy=%b want 0 00 0",
               bus.fifo_wr_en, bus.fifo_wr_din, bus.s_ready);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic check_seq(string nm, int n, logic [DW-1:0] base);
    logic [DW-1:0] exp;
    total++;
    if (wq.size() != n) begin
      bad++;
      $display("FAIL %s_writes got=%0d want=%0d", nm, wq.size(), n);
    end
    for (int i = 0; i < wq.size() && i < n; i++) begin
      exp = base + DW'(i);
      total++;
      if (wq[i] !== exp) begin
        bad++;
        $display("FAIL %s_data[%0d] got=%h want=%h",
                 nm, i, wq[i], exp);
      end
    end
  endtask

  task automatic test_basic();
    clear_mon();
    bus.s_data  = 8'h10;
    bus.s_valid = 1'b1;
    start       = 1'b1;
    burst_len   = 16'd8;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy_on got=%b want=1", busy);
    end
    for (int k = 0; k < 10; k++) step();
    bus.s_valid = 1'b0;
    check_seq("basic", 8, 8'h10);
    total++;
    if (n_done != 1 || n_done_wr != 1) begin
      bad++;
      $display("FAIL basic_done pulses=%0d with_wr=%0d want 1 1",
               n_done, n_done_wr);
    end
    total++;
    if (wr_count !== 16'd8) begin
      bad++;
      $display("FAIL basic_count got=%0d want=8", wr_count);
    end
    total++;
    if (n_busy != 8 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy cycles=%0d now=%b want 8 0",
               n_busy, busy);
    end
  endtask

  task automatic test_throttle();
    logic [15:0] exp_stall;
`ifdef WR_STALL_CNT_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    clear_mon();
    bus.s_data  = 8'h40;
    bus.s_valid = 1'b1;
    start       = 1'b1;
    burst_len   = 16'd20;
    step();
    start = 1'b0;
    for (int k = 0; k < 28; k++) begin
      bus.fifo_almost_full = (k >= 5 && k <= 9);
      bus.fifo_full        = (k == 7);
      #1;
      if (k >= 5 && k <= 9) begin
        total++;
        if (bus.s_ready !== 1'b0) begin
          bad++;
          $display("FAIL throttle_ready cyc=%0d got=%b want=0",
                   k, bus.s_ready);
        end
      end
      step();
    end
    bus.s_valid = 1'b0;
    check_seq("throttle", 20, 8'h40);
    total++;
    if (n_clash != 0) begin
      bad++;
      $display("FAIL throttle_full_wr got=%0d want=0", n_clash);
    end
    total++;
    if (n_done != 1 || wr_count !== 16'd20) begin
      bad++;
      $display("FAIL throttle_end done=%0d cnt=%0d want 1 20",
               n_done, wr_count);
    end
    total++;
    if (stall_cnt !== exp_stall) begin
      bad++;
      $display("FAIL throttle_stall got=%0d want=%0d",
               stall_cnt, exp_stall);
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    bus.s_valid = 1'b1;
    start       = 1'b1;
    burst_len   = 16'd0;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    bus.s_valid = 1'b0;
    total++;
    if (wq.size() != 0 || n_done != 1 || n_busy != 0) begin
      bad++;
      $display("FAIL zero_len wr=%0d done=%0d busy=%0d want 0 1 0",
               wq.size(), n_done, n_busy);
    end
    total++;
    if (wr_count !== 16'd0 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL zero_cnt cnt=%0d stall=%0d want 0 0",
               wr_count, stall_cnt);
    end
  endtask

  task automatic test_abort();
    clear_mon();
    bus.s_data  = 8'h80;
    bus.s_valid = 1'b1;
    start       = 1'b1;
    burst_len   = 16'd16;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    bus.s_valid = 1'b0;
    abort       = 1'b1;
    step();
    abort = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check_seq("abort", 6, 8'h80);
    total++;
    if (n_done != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_state done=%0d busy=%b want 0 0",
               n_done, busy);
    end
    total++;
    if (wr_count !== 16'd6) begin
      bad++;
      $display("FAIL abort_count got=%0d want=6", wr_count);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    bus.s_data  = 8'hA0;
    bus.s_valid = 1'b1;
    start       = 1'b1;
    burst_len   = 16'd10;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    start     = 1'b1;
    burst_len = 16'd5;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    bus.s_valid = 1'b0;
    check_seq("restart", 10, 8'hA0);
    total++;
    if (n_done != 1 || wr_count !== 16'd10) begin
      bad++;
      $display("FAIL restart_end done=%0d cnt=%0d want 1 10",
               n_done, wr_count);
    end
  endtask

  task automatic test_reset_mid();
    bus.s_data  = 8'h20;
    bus.s_valid = 1'b1;
    start       = 1'b1;
    burst_len   = 16'd8;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_count !== 16'd0
        || bus.fifo_wr_en !== 1'b0 || bus.fifo_wr_din !== 8'd0
        || stall_cnt !== 16'd0 || bus.s_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid busy=%b done=%b cnt=%0d wr=%b din=%h st=%0d want all 0",
               busy, done, wr_count, bus.fifo_wr_en,
               bus.fifo_wr_din, stall_cnt);
    end
    bus.s_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    clear_mon();
    bus.s_data  = 8'h50;
    bus.s_valid = 1'b1;
    start       = 1'b1;
    burst_len   = 16'd4;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    bus.s_valid = 1'b0;
    check_seq("after_rst", 4, 8'h50);
    total++;
    if (wr_count !== 16'd4 || n_done != 1) begin
      bad++;
      $display("FAIL after_rst_end cnt=%0d done=%0d want 4 1",
               wr_count, n_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_throttle();
    test_zero_len();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
